// File: rtl/bowling_pkg.sv
// Shared constants and frame-state type for the bowling score keeper.
package bowling_pkg;

    localparam int NUM_FRAMES = 10;
    localparam int MAX_PINS   = 10;
    localparam int FRAME_W    = 6;
    localparam int TOTAL_W    = 11;

    typedef struct packed {
        logic [FRAME_W-1:0] score;
        logic [1:0]         bonus_cnt;
    } frame_t;

    typedef enum logic [1:0] {
        ST_BALL1,
        ST_BALL2,
        ST_FILL,
        ST_DONE
    } roll_state_e;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-cycle rising-edge pulse.
module button_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 1 so a level already high when reset releases is not taken as a new press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= level_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/bowling_scorer.sv
// Single-player ten-pin score keeper: one roll per button press, strike/spare bonuses resolved live.
module bowling_scorer
    import bowling_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         point_in,
    input  logic               button,
    output logic [TOTAL_W-1:0] point_all,
    output logic [FRAME_W-1:0] frame_score_1,
    output logic [FRAME_W-1:0] frame_score_2,
    output logic [FRAME_W-1:0] frame_score_3,
    output logic [FRAME_W-1:0] frame_score_4,
    output logic [FRAME_W-1:0] frame_score_5,
    output logic [FRAME_W-1:0] frame_score_6,
    output logic [FRAME_W-1:0] frame_score_7,
    output logic [FRAME_W-1:0] frame_score_8,
    output logic [FRAME_W-1:0] frame_score_9,
    output logic [FRAME_W-1:0] frame_score_10,
    output logic               game_over
);

    function automatic logic [3:0] clamp_pins(input logic [3:0] raw, input logic [3:0] standing);
        return (raw > standing) ? standing : raw;
    endfunction

    logic        roll_stb;
    frame_t      frames_q [NUM_FRAMES];
    frame_t      frames_d [NUM_FRAMES];
    logic [3:0]  frame_idx_q, frame_idx_d;
    logic [3:0]  rack_q, rack_d;
    roll_state_e state_q, state_d;

    logic [3:0]  pins;
    logic [3:0]  left;
    logic        last_frame;
    logic        set_strike;
    logic        set_spare;
    logic [TOTAL_W-1:0] total;

    button_edge_sync u_btn (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .level_i (button),
        .rise_o  (roll_stb)
    );

    always_comb begin
        frames_d    = frames_q;
        frame_idx_d = frame_idx_q;
        rack_d      = rack_q;
        state_d     = state_q;
        pins        = clamp_pins(point_in, rack_q);
        left        = rack_q - pins;
        last_frame  = (frame_idx_q == 4'(NUM_FRAMES - 1));
        set_strike  = 1'b0;
        set_spare   = 1'b0;

        if (roll_stb && state_q != ST_DONE) begin
            // A cleared rack is re-racked; frame advances override this below.
            rack_d = (left == 4'd0) ? 4'(MAX_PINS) : left;

            unique case (state_q)
                ST_BALL1: begin
                    if (!last_frame && left == 4'd0) begin
                        set_strike  = 1'b1;
                        frame_idx_d = frame_idx_q + 4'd1;
                    end else begin
                        state_d = ST_BALL2;
                    end
                end
                ST_BALL2: begin
                    if (!last_frame) begin
                        set_spare   = (left == 4'd0);
                        frame_idx_d = frame_idx_q + 4'd1;
                        rack_d      = 4'(MAX_PINS);
                        state_d     = ST_BALL1;
                    end else if (frames_q[NUM_FRAMES-1].score == FRAME_W'(MAX_PINS) || left == 4'd0) begin
                        // Frame 10 still holds only ball 1 here, so score==10 means a strike.
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_DONE;
            endcase

            for (int i = 0; i < NUM_FRAMES; i++) begin
                if (4'(i) == frame_idx_q) begin
                    frames_d[i].score = frames_q[i].score + FRAME_W'(pins);
                    if (set_strike)
                        frames_d[i].bonus_cnt = 2'd2;
                    else if (set_spare)
                        frames_d[i].bonus_cnt = 2'd1;
                end else if (4'(i) < frame_idx_q && frames_q[i].bonus_cnt != 2'd0) begin
                    frames_d[i].score     = frames_q[i].score + FRAME_W'(pins);
                    frames_d[i].bonus_cnt = frames_q[i].bonus_cnt - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_FRAMES; i++)
                frames_q[i] <= '0;
            frame_idx_q <= 4'd0;
            rack_q      <= 4'(MAX_PINS);
            state_q     <= ST_BALL1;
        end else begin
            frames_q    <= frames_d;
            frame_idx_q <= frame_idx_d;
            rack_q      <= rack_d;
            state_q     <= state_d;
        end
    end

    always_comb begin
        total = '0;
        for (int i = 0; i < NUM_FRAMES; i++)
            total = total + TOTAL_W'(frames_q[i].score);
    end

    assign point_all      = total;
    assign game_over      = (state_q == ST_DONE);
    assign frame_score_1  = frames_q[0].score;
    assign frame_score_2  = frames_q[1].score;
    assign frame_score_3  = frames_q[2].score;
    assign frame_score_4  = frames_q[3].score;
    assign frame_score_5  = frames_q[4].score;
    assign frame_score_6  = frames_q[5].score;
    assign frame_score_7  = frames_q[6].score;
    assign frame_score_8  = frames_q[7].score;
    assign frame_score_9  = frames_q[8].score;
    assign frame_score_10 = frames_q[9].score;

endmodule

// File: tb/tb_bowling_scorer.sv
// Directed bench for bowling_scorer: hand-scored games compared frame by frame.
module tb_bowling_scorer;

    logic        clk;
    logic        reset_n;
    logic [3:0]  point_in;
    logic        button;
    logic [10:0] point_all;
    logic [5:0]  fs [10];
    logic        game_over;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    bowling_scorer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .point_in       (point_in),
        .button         (button),
        .point_all      (point_all),
        .frame_score_1  (fs[0]),
        .frame_score_2  (fs[1]),
        .frame_score_3  (fs[2]),
        .frame_score_4  (fs[3]),
        .frame_score_5  (fs[4]),
        .frame_score_6  (fs[5]),
        .frame_score_7  (fs[6]),
        .frame_score_8  (fs[7]),
        .frame_score_9  (fs[8]),
        .frame_score_10 (fs[9]),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_game(input string tag, input int exp[10], input int tot, input int go);
        #1;
        for (int i = 0; i < 10; i++)
            check($sformatf("%s frame%0d", tag, i + 1), int'(fs[i]), exp[i]);
        check({tag, " point_all"}, int'(point_all), tot);
        check({tag, " game_over"}, int'(game_over), go);
    endtask

    task automatic roll(input int v, input int hold = 4);
        point_in = 4'(v);
        button   = 1'b1;
        repeat (hold) @(posedge clk);
        button   = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    int g2[8]   = '{10, 7, 3, 3, 4, 3, 5, 2};
    int e2[10]  = '{20, 13, 7, 8, 2, 0, 0, 0, 0, 0};
    int g3[23]  = '{3, 5, 2, 3, 4, 3, 5, 2, 1, 3, 2, 1, 7, 1, 3, 5, 2, 3, 3, 5, 2, 3, 3};
    int e3[10]  = '{8, 5, 7, 7, 4, 3, 8, 8, 5, 8};
    int e4[10]  = '{30, 30, 30, 30, 30, 30, 30, 30, 30, 30};
    int e0[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int g5a[4]  = '{12, 6, 7, 3};
    int e5a[10] = '{20, 13, 3, 0, 0, 0, 0, 0, 0, 0};
    int e5b[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 10};
    int e5c[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 17};
    int e6a[10] = '{4, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int e6b[10] = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int e6c[10] = '{6, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        reset_n  = 1'b0;
        button   = 1'b0;
        point_in = 4'd0;

        do_reset();
        repeat (10) @(posedge clk);
        check_game("reset", e0, 0, 0);

        foreach (g2[i]) roll(g2[i]);
        check_game("mixed", e2, 50, 0);

        do_reset();
        for (int i = 0; i < 20; i++) roll(g3[i]);
        check_game("open", e3, 63, 1);
        for (int i = 20; i < 23; i++) roll(g3[i]);
        check_game("open_after", e3, 63, 1);

        do_reset();
        repeat (12) roll(10);
        check_game("perfect", e4, 300, 1);
        roll(10);
        check_game("perfect_13", e4, 300, 1);

        do_reset();
        foreach (g5a[i]) roll(g5a[i]);
        check_game("clamp", e5a, 36, 0);

        do_reset();
        repeat (18) roll(0);
        roll(5);
        roll(5);
        check_game("tenth_spare", e5b, 10, 0);
        roll(7);
        check_game("tenth_fill", e5c, 17, 1);

        do_reset();
        roll(4, 50);
        check_game("long_hold", e6a, 4, 0);
        roll(3);
        check_game("second_ball", e6b, 7, 0);
        do_reset();
        check_game("mid_reset", e0, 0, 0);
        roll(6);
        check_game("after_reset", e6c, 6, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bowling_scorer.md
Name: bowling_scorer

Overview:
- Ten-pin bowling score keeper for a single player.
- Each press of a roll button registers the pin count on `point_in` as one roll.
- Strike and spare bonuses are resolved automatically.
- Exposes the ten per-frame scores plus the running game total to a display or front-panel layer.

Parameters:
- NUM_FRAMES, 10, number of frames in a game (fixed at 10; the 10th-frame rules assume this value).
- FRAME_W, 6, width of each frame score (max 30).
- TOTAL_W, 11, width of the game total (max 300).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset; clears all state.
- point_in  in  4  pins knocked down by the current roll.
- button  in  1  roll strobe, asynchronous to clk, level held for many cycles per press.
- point_all  out  11  sum of all frame scores.
- frame_score_1 … frame_score_10  out  6 each  ten separate ports, accumulated score of frames 1..10.
- game_over  out  1  high once frame 10 is complete; further rolls are ignored.

Behaviour:
Reset
- All outputs read 0 after reset.
- Internal state cleared: frame index = 1, roll-in-frame = 1, rack = 10, all bonus counters = 0.
- Reset mid-game discards the game immediately.

Button handling
- `button` passes through a 2-flop synchronizer, then a rising-edge detector.
- One detected edge equals exactly one roll, regardless of how long `button` is held.
- `point_in` is sampled on the cycle the edge is detected.
- Outputs update on the next clock edge (1-cycle latency from the detected edge).

Pin clamping
- The roll value is min(`point_in`, pins standing).
- Pins standing = 10 on the first ball of a frame or on a fresh rack; otherwise 10 minus the previous ball.

Scoring: each roll value v is processed as follows
- Add v to the current frame.
- Add v to every earlier frame whose bonus counter is nonzero, then decrement that counter.
- At most two earlier frames can be pending at once.

Frames 1..9
- First ball v = 10 (strike): set that frame's bonus counter to 2 and advance to the next frame.
- Otherwise wait for the second ball.
  - If the two balls sum to 10 (spare), set the bonus counter to 1.
  - Advance to the next frame after the second ball.

Frame 10
- Strike on ball 1 grants two fill balls.
- Spare on ball 2 grants one fill ball.
- Otherwise the game ends after ball 2.
- Fill balls add only to frame 10, apart from bonus credits still owed to frames 8 and 9. No further bonus counters are created.
- The rack resets to 10 after a strike or spare within frame 10.
- `game_over` asserts on the update cycle of the last ball.

Outputs and boundaries
- Frame scores are live: partial frames and frames still awaiting bonus show their current accumulated value.
- `point_all` = sum of all `frame_score_*`.
- While `game_over` = 1, button edges are ignored and outputs hold.
- Only `reset_n` restarts the game.
- A button edge coinciding with reset deassertion is ignored.
- No overflow is possible: frame max 30, total max 300.

Decomposition:
- Shared package `bowling_pkg` holds:
  - constants NUM_FRAMES, MAX_PINS = 10, FRAME_W, TOTAL_W;
  - a frame-state typedef holding score (6b) and bonus_cnt (2b).
- Sub-module `button_edge_sync`: 2-flop synchronizer plus rising-edge pulse, reusable.
- Scoring FSM, frame array and total adder stay in the top module.

Test Plan:
1. Reset, then no presses → all ten frame scores, `point_all` and `game_over` read 0.
2. Rolls 10,7,3,3,4,3,5,2 → frames 20,13,7,8,2, rest 0; `point_all` = 50; `game_over` = 0.
3. Twenty rolls 3,5,2,3,4,3,5,2,1,3,2,1,7,1,3,5,2,3,3,5, then presses 2,3,3:
   - frames 8,5,7,7,4,3,8,8,5,8;
   - `point_all` = 63;
   - `game_over` = 1;
   - the extra presses change nothing.
4. Twelve strikes → every frame 30, `point_all` = 300, `game_over` = 1; a 13th press is ignored.
5. Clamping and 10th-frame spare:
   - `point_in` = 12 → counted as a strike (10).
   - 6 then 7 → second ball counted as 4 (spare).
   - 18 zeros then 5,5,7 → frame 10 = 17, `game_over` after the fill ball.
6. Button held high for 50 cycles → counted as one roll. `reset_n` pulsed mid-game → all outputs 0 and the next roll lands in frame 1.
